iterative_shifter_unit: RTL and testbench
=========================================

// Module: iterative_shifter_unit
// PURPOSE
//  Multi-cycle shifter for the CPU datapath: SLL/SRL/SRA/ROTL by a variable amount.
//  Generalises the fixed shift-left-by-2 helper to runtime amount, mode and width.
//  Shifts up to STEP bits per clock, trading latency for area.
//  Sits beside the ALU and uses valid/ready handshakes on both input and output sides.
// PARAMETERS
//  DATA_SIZE  32                  operand width; power of two, >= 8
//  STEP       4                   max bits shifted per clock; 1..DATA_SIZE-1
//  SHAMT_W    $clog2(DATA_SIZE)   shift-amount width (derived; do not override)
// PORTS
//  Clk       in   1          clock, rising edge
//  Reset     in   1          asynchronous, active-high reset
//  InValid   in   1          request valid
//  InReady   out  1          unit can accept a request
//  In        in   DATA_SIZE  operand
//  Shamt     in   SHAMT_W    shift amount, 0..DATA_SIZE-1
//  Mode      in   2          00 SLL, 01 SRL, 10 SRA, 11 ROTL
//  OutValid  out  1          result valid
//  OutReady  in   1          consumer takes result
//  Out       out  DATA_SIZE  result (registered)
//  Busy      out  1          state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE -> SHIFT on accept when Shamt != 0.
//    IDLE -> DONE on accept when Shamt == 0.
//    SHIFT -> DONE when remaining amount reaches 0.
//    DONE -> IDLE on OutValid && OutReady.
//  - InReady = (state == IDLE) && !Reset (combinational).
//    Accept = InValid && InReady.
//    In, Shamt and Mode are sampled only at accept; later changes are ignored.
//  - Accept edge: data register <= In; remaining <= Shamt; mode register <= Mode.
//  - Each SHIFT edge:
//    - Shift by k = min(STEP, remaining); remaining -= k.
//    - SLL/SRL fill with 0.
//    - SRA fills with the ORIGINAL sign bit, held in the mode register.
//    - ROTL wraps MSBs into LSBs.
//  - Latency: OutValid asserts 1 + ceil(Shamt/STEP) clocks after the accept edge.
//    Example: Shamt = 0 gives 1 clock.
//  - DONE: OutValid = 1; Out is held stable until the handshake.
//    - Out and OutValid must not change while OutReady = 0.
//    - Handshake edge returns to IDLE. No new request is accepted in that same cycle,
//      because InReady = 0 in DONE.
//  - Out = data register. It keeps the last result in IDLE; intermediate values in SHIFT
//    are not qualified.
//  - Reset (asynchronous, any state, including mid-SHIFT):
//    - state = IDLE, Out = 0, OutValid = 0, Busy = 0, remaining = 0.
//    - InReady = 0 while Reset is high and 1 on the first cycle after release.
//    - Any in-flight request is discarded.
//  - Width rules:
//    - remaining is SHAMT_W bits and never underflows (k <= remaining).
//    - The per-step amount is $clog2(STEP+1) bits.
//  - X on Mode or Shamt while InValid is low has no effect.
// STRUCTURE
//  - Package shifter_pkg: mode localparams (SH_SLL=2'b00, SH_SRL, SH_SRA, SH_ROTL) and the
//    FSM state encoding (IDLE, SHIFT, DONE; 2 bits).
//  - Sub-module shift_step: combinational shift of DATA_SIZE bits by 0..STEP, given mode
//    and fill bit.
//  - The top module holds the FSM, data/remaining/mode registers and handshake logic.
// TESTING  (DATA_SIZE=32, STEP=4)
//  1. SLL In=0x00000001 Shamt=31 -> Out=0x80000000, OutValid 9 clocks after accept.
//  2. SRA In=0x80000000 Shamt=4 -> Out=0xF8000000 after 2 clocks.
//     SRL with the same operands -> 0x08000000.
//  3. SRL In=0x12345678 Shamt=0 -> Out=0x12345678, OutValid 1 clock after accept.
//  4. ROTL In=0x80000001 Shamt=5 -> Out=0x00000030 after 3 clocks.
//  5. Hold OutReady=0 for 5 clocks in DONE, with InValid=1 and new operands:
//     -> Out and OutValid stable, InReady=0, no new accept.
//     Release OutReady -> IDLE next clock.
//  6. Assert Reset during SHIFT (test 1, 3rd shift clock):
//     -> OutValid=0, Out=0, Busy=0 immediately.
//     After release -> InReady=1, and a fresh SLL 0x1 by 1 returns 0x2.

Source files
------------

// File: rtl/iterative_shifter_unit_pkg.sv
// rtl/iterative_shifter_unit_pkg.sv - shift modes, FSM encoding and mode register layout
package shifter_pkg;

    localparam logic [1:0] SH_SLL  = 2'b00;
    localparam logic [1:0] SH_SRL  = 2'b01;
    localparam logic [1:0] SH_SRA  = 2'b10;
    localparam logic [1:0] SH_ROTL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The sign bit travels with the mode so SRA fills from the original operand
    typedef struct packed {
        logic [1:0] mode;
        logic       sign;
    } mode_reg_t;

endpackage

// File: rtl/iterative_shifter_unit_if.sv
// rtl/iterative_shifter_unit_if.sv - request/response handshake bundle for the shifter
interface iterative_shifter_unit_if #(
    parameter int DATA_SIZE = 32
);
    localparam int SHAMT_W = $clog2(DATA_SIZE);

    logic                 InValid;
    logic                 InReady;
    logic [DATA_SIZE-1:0] In;
    logic [SHAMT_W-1:0]   Shamt;
    logic [1:0]           Mode;
    logic                 OutValid;
    logic                 OutReady;
    logic [DATA_SIZE-1:0] Out;
    logic                 Busy;

    modport master (
        output InValid, In, Shamt, Mode, OutReady,
        input  InReady, OutValid, Out, Busy
    );

    modport slave (
        input  InValid, In, Shamt, Mode, OutReady,
        output InReady, OutValid, Out, Busy
    );

endinterface

// File: rtl/iterative_shifter_unit_shift_step.sv
// rtl/iterative_shifter_unit_shift_step.sv - combinational shift of one word by 0..STEP bits
module shift_step
    import shifter_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int STEP      = 4,
    parameter int STEP_W    = $clog2(STEP + 1)
) (
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic [STEP_W-1:0]    amt,
    input  logic [1:0]           mode,
    input  logic                 fill,
    output logic [DATA_SIZE-1:0] data_out
);

    localparam logic [DATA_SIZE-1:0] ALL_ONES = {DATA_SIZE{1'b1}};

    logic [DATA_SIZE-1:0] fill_mask;

    // Select the shift flavour; SRA ORs the fill bit into the vacated MSBs
    always_comb begin
        fill_mask = ~(ALL_ONES >> amt);
        data_out  = data_in;
        case (mode)
            SH_SLL:  data_out = data_in << amt;
            SH_SRL:  data_out = data_in >> amt;
            SH_SRA:  data_out = (data_in >> amt) | ({DATA_SIZE{fill}} & fill_mask);
            SH_ROTL: data_out = (data_in << amt) | (data_in >> (DATA_SIZE - int'(amt)));
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/iterative_shifter_unit.sv
// rtl/iterative_shifter_unit.sv - multi-cycle SLL/SRL/SRA/ROTL shifter, STEP bits per clock
module iterative_shifter_unit
    import shifter_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int STEP      = 4
) (
    input  logic                      Clk,
    input  logic                      Reset,
    iterative_shifter_unit_if.slave   bus
);

    localparam int SHAMT_W = $clog2(DATA_SIZE);
    localparam int STEP_W  = $clog2(STEP + 1);
    localparam logic [SHAMT_W-1:0] STEP_SH = SHAMT_W'(STEP);
    localparam logic [STEP_W-1:0]  STEP_K  = STEP_W'(STEP);

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [SHAMT_W-1:0]   remaining_q, remaining_d;
    mode_reg_t            mode_q, mode_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic                 in_ready;
    logic                 accept;
    logic [STEP_W-1:0]    step_k;
    logic [DATA_SIZE-1:0] step_out;

    assign in_ready = (state_q == IDLE) && !Reset;
    assign accept   = bus.InValid && in_ready;

    // Per-step amount is min(STEP, remaining) so remaining can never underflow
    assign step_k = (remaining_q >= STEP_SH) ? STEP_K : remaining_q[STEP_W-1:0];

    shift_step #(
        .DATA_SIZE (DATA_SIZE),
        .STEP      (STEP),
        .STEP_W    (STEP_W)
    ) u_shift_step (
        .data_in  (data_q),
        .amt      (step_k),
        .mode     (mode_q.mode),
        .fill     (mode_q.sign),
        .data_out (step_out)
    );

    // Next-state and datapath: sample operands on accept, shift in SHIFT, hold in DONE
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d      = bus.In;
                    remaining_d = bus.Shamt;
                    mode_d.mode = bus.Mode;
                    mode_d.sign = bus.In[DATA_SIZE-1];
                    busy_d      = 1'b1;
                    if (bus.Shamt == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_d      = step_out;
                remaining_d = remaining_q - SHAMT_W'(step_k);
                if (remaining_q == SHAMT_W'(step_k)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.OutReady) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // FSM and its registered outputs; reset discards any in-flight request
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            remaining_q <= '0;
            mode_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid_q;
    assign bus.Out      = data_q;
    assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_iterative_shifter_unit.sv
// tb/tb_iterative_shifter_unit.sv - directed self-checking bench for iterative_shifter_unit
module tb_iterative_shifter_unit;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    iterative_shifter_unit_if #(.DATA_SIZE(32)) bus ();

    iterative_shifter_unit #(
        .DATA_SIZE (32),
        .STEP      (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one request, then count clocks from the accept edge until OutValid
    task automatic issue(input logic [31:0] din, input logic [4:0] sh, input logic [1:0] md,
                         output int lat);
        @(negedge Clk);
        bus.InValid = 1'b1;
        bus.In      = din;
        bus.Shamt   = sh;
        bus.Mode    = md;
        @(posedge Clk);
        #1;
        bus.InValid = 1'b0;
        bus.In      = 32'hDEADBEEF;
        bus.Shamt   = 5'd17;
        bus.Mode    = 2'b11;
        lat = 1;
        while (!bus.OutValid && lat < 40) begin
            @(posedge Clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_result();
        @(negedge Clk);
        bus.OutReady = 1'b1;
        @(posedge Clk);
        #1;
        bus.OutReady = 1'b0;
    endtask

    task automatic test_reset();
        Reset        = 1'b1;
        bus.InValid  = 1'b1;
        bus.In       = 32'h12345678;
        bus.Shamt    = 5'd3;
        bus.Mode     = 2'b00;
        bus.OutReady = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if (bus.InReady !== 1'b0) begin
            errors++; $display("FAIL reset_inready got %b want 0", bus.InReady);
        end
        checks++;
        if (bus.OutValid !== 1'b0 || bus.Busy !== 1'b0 || bus.Out !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b busy=%b out=%h want 0 0 00000000",
                     bus.OutValid, bus.Busy, bus.Out);
        end
        bus.InValid = 1'b0;
        Reset = 1'b0;
        #1;
        checks++;
        if (bus.InReady !== 1'b1) begin
            errors++; $display("FAIL reset_release_inready got %b want 1", bus.InReady);
        end
    endtask

    task automatic test_shifts();
        logic [31:0] v_in  [8] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h12345678,
                                   32'h80000001, 32'h80000000, 32'h12345678, 32'h12345678};
        logic [4:0]  v_sh  [8] = '{5'd31, 5'd4, 5'd4, 5'd0, 5'd5, 5'd31, 5'd8, 5'd31};
        logic [1:0]  v_md  [8] = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
        logic [31:0] v_out [8] = '{32'h80000000, 32'hF8000000, 32'h08000000, 32'h12345678,
                                   32'h00000030, 32'hFFFFFFFF, 32'h34567812, 32'h00000000};
        int          v_lat [8] = '{9, 2, 2, 1, 3, 9, 3, 9};
        int lat;
        for (int i = 0; i < 8; i++) begin
            issue(v_in[i], v_sh[i], v_md[i], lat);
            checks++;
            if (lat !== v_lat[i]) begin
                errors++; $display("FAIL shift%0d_latency got %0d want %0d", i, lat, v_lat[i]);
            end
            checks++;
            if (bus.Out !== v_out[i]) begin
                errors++; $display("FAIL shift%0d_out got %h want %h", i, bus.Out, v_out[i]);
            end
            take_result();
            checks++;
            if (bus.OutValid !== 1'b0 || bus.Busy !== 1'b0 || bus.InReady !== 1'b1) begin
                errors++;
                $display("FAIL shift%0d_handshake got valid=%b busy=%b inready=%b want 0 0 1",
                         i, bus.OutValid, bus.Busy, bus.InReady);
            end
            checks++;
            if (bus.Out !== v_out[i]) begin
                errors++; $display("FAIL shift%0d_idle_hold got %h want %h", i, bus.Out, v_out[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(32'h00000003, 5'd2, 2'b00, lat);
        checks++;
        if (lat !== 2 || bus.Out !== 32'h0000000C) begin
            errors++; $display("FAIL bp_first got lat=%0d out=%h want 2 0000000c", lat, bus.Out);
        end
        @(negedge Clk);
        bus.InValid = 1'b1;
        bus.In      = 32'hFFFF0000;
        bus.Shamt   = 5'd1;
        bus.Mode    = 2'b01;
        for (int c = 0; c < 5; c++) begin
            @(posedge Clk);
            #1;
            checks++;
            if (bus.Out !== 32'h0000000C || bus.OutValid !== 1'b1 || bus.InReady !== 1'b0
                || bus.Busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d got out=%h valid=%b inready=%b busy=%b want 0000000c 1 0 1",
                         c, bus.Out, bus.OutValid, bus.InReady, bus.Busy);
            end
        end
        @(negedge Clk);
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        @(posedge Clk);
        #1;
        bus.OutReady = 1'b0;
        checks++;
        if (bus.Busy !== 1'b0 || bus.OutValid !== 1'b0 || bus.InReady !== 1'b1
            || bus.Out !== 32'h0000000C) begin
            errors++;
            $display("FAIL bp_release got busy=%b valid=%b inready=%b out=%h want 0 0 1 0000000c",
                     bus.Busy, bus.OutValid, bus.InReady, bus.Out);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        @(negedge Clk);
        bus.InValid = 1'b1;
        bus.In      = 32'h00000001;
        bus.Shamt   = 5'd31;
        bus.Mode    = 2'b00;
        @(posedge Clk);
        #1;
        bus.InValid = 1'b0;
        repeat (2) begin
            @(posedge Clk);
            #1;
        end
        checks++;
        if (bus.Busy !== 1'b1 || bus.Out !== 32'h00000100 || bus.OutValid !== 1'b0) begin
            errors++;
            $display("FAIL midshift_state got busy=%b out=%h valid=%b want 1 00000100 0",
                     bus.Busy, bus.Out, bus.OutValid);
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.OutValid !== 1'b0 || bus.Out !== 32'h0 || bus.Busy !== 1'b0
            || bus.InReady !== 1'b0) begin
            errors++;
            $display("FAIL midshift_reset got valid=%b out=%h busy=%b inready=%b want 0 00000000 0 0",
                     bus.OutValid, bus.Out, bus.Busy, bus.InReady);
        end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checks++;
        if (bus.InReady !== 1'b1) begin
            errors++; $display("FAIL midshift_release_inready got %b want 1", bus.InReady);
        end
        issue(32'h00000001, 5'd1, 2'b00, lat);
        checks++;
        if (lat !== 2 || bus.Out !== 32'h00000002) begin
            errors++;
            $display("FAIL midshift_fresh got lat=%0d out=%h want 2 00000002", lat, bus.Out);
        end
        take_result();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_shifts();
        test_backpressure();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
